seven_seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a NUM_DIGITS common-anode 7-segment bank.

---
 rtl/seven_seg_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank, with a blanking gap
// between digits, frame-aligned value updates and optional leading-zero blanking.
module seven_seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned DWELL_CYCLES = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lzb_en,
   output logic [6:0]              seg,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_start
);

   localparam int unsigned CntMaxDb = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int unsigned CntMax   = (CntMaxDb > 2) ? CntMaxDb : 2;
   localparam int unsigned CntW     = $clog2(CntMax);
   localparam int unsigned IdxW     = $clog2(NUM_DIGITS);
   localparam bit          NoBlank  = (BLANK_CYCLES == 0);

   localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
   localparam logic [CntW-1:0] BlankLast = NoBlank ? '0 : CntW'(BLANK_CYCLES - 1);
   localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

   typedef enum logic {StBlank, StShow} state_e;

   state_e                  state_q;
   logic [CntW-1:0]         cnt_q;
   logic [IdxW-1:0]         idx_q;
   logic [4*NUM_DIGITS-1:0] active_q;
   logic [4*NUM_DIGITS-1:0] pending_q;
   logic                    pend_vld_q;

   logic                    leaving_show;
   logic                    boundary;
   logic                    enter_show;
   logic [IdxW-1:0]         idx_nxt;
   logic [IdxW-1:0]         show_idx;
   logic [4*NUM_DIGITS-1:0] active_d;
   logic [3:0]              nib;
   logic                    dp_sel;
   logic                    lead_zero;
   logic                    lz_blank;

   // Segment pattern in {g,f,e,d,c,b,a} bit order, active-low.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   always_comb begin
      leaving_show = (state_q == StShow) && (cnt_q == DwellLast);
      boundary     = leaving_show && (idx_q == IdxLast);
      idx_nxt      = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
      show_idx     = (state_q == StShow) ? idx_nxt : idx_q;
      if (state_q == StBlank) begin
         enter_show = NoBlank || (cnt_q == BlankLast);
      end else begin
         enter_show = NoBlank && leaving_show;
      end

      // A load on the boundary edge bypasses the pending buffer for the frame now starting.
      active_d = active_q;
      if (boundary) begin
         if (load) begin
            active_d = value_in;
         end else if (pend_vld_q) begin
            active_d = pending_q;
         end
      end
   end

   // Scan from the top nibble down so lead_zero marks "this and all higher nibbles are 0".
   always_comb begin
      lead_zero = 1'b1;
      lz_blank  = 1'b0;
      nib       = 4'h0;
      dp_sel    = 1'b0;
      for (int j = int'(NUM_DIGITS) - 1; j >= 0; j--) begin
         if (active_d[4*j +: 4] != 4'h0) begin
            lead_zero = 1'b0;
         end
         if (IdxW'(j) == show_idx) begin
            nib      = active_d[4*j +: 4];
            dp_sel   = dp_in[j];
            lz_blank = lead_zero && (j != 0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StBlank;
         cnt_q       <= '0;
         idx_q       <= '0;
         active_q    <= '0;
         pending_q   <= '0;
         pend_vld_q  <= 1'b0;
         seg         <= 7'h7F;
         dp_n        <= 1'b1;
         an_n        <= '1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= boundary;
         active_q    <= active_d;
         if (boundary) begin
            pend_vld_q <= 1'b0;
         end else if (load) begin
            pending_q  <= value_in;
            pend_vld_q <= 1'b1;
         end

         if (leaving_show) begin
            idx_q <= idx_nxt;
         end

         if (enter_show) begin
            state_q <= StShow;
            cnt_q   <= '0;
            an_n    <= ~(NUM_DIGITS'(1) << show_idx);
            seg     <= (lzb_en && lz_blank) ? 7'h7F : hex_to_seg(nib);
            dp_n    <= ~dp_sel;
         end else if (leaving_show) begin
            state_q <= StBlank;
            cnt_q   <= '0;
            an_n    <= '1;
            seg     <= 7'h7F;
            dp_n    <= 1'b1;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: stimulus queues expected digit displays per frame,
// a negedge monitor pops and compares them and checks dwell, blank gap and frame period.
module tb_seven_seg_scan_ctrl;

   localparam int unsigned Dwell = 4;
   localparam int unsigned Blank = 2;
   localparam int unsigned Frame = 24;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] SA = 7'b0001000;
   localparam logic [6:0] SB = 7'b0000011;
   localparam logic [6:0] SC = 7'b1000110;
   localparam logic [6:0] SD = 7'b0100001;
   localparam logic [6:0] SF = 7'b0001110;
   localparam logic [6:0] SX = 7'h7F;

   logic        clk;
   logic        rst_n;
   logic [15:0] value_in;
   logic        load;
   logic [3:0]  dp_in;
   logic        lzb_en;
   logic [6:0]  seg;
   logic        dp_n;
   logic [3:0]  an_n;
   logic        frame_start;

   seven_seg_scan_ctrl #(
      .NUM_DIGITS   (4),
      .DWELL_CYCLES (Dwell),
      .BLANK_CYCLES (Blank)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value_in    (value_in),
      .load        (load),
      .dp_in       (dp_in),
      .lzb_en      (lzb_en),
      .seg         (seg),
      .dp_n        (dp_n),
      .an_n        (an_n),
      .frame_start (frame_start)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp_n;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks;
   int   n_fail;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                             input logic [6:0] s0, input logic [3:0] dp);
      logic [6:0] s [4];
      exp_t       e;
      s[0] = s0;
      s[1] = s1;
      s[2] = s2;
      s[3] = s3;
      for (int i = 0; i < 4; i++) begin
         e.an   = ~(4'(1) << i);
         e.seg  = s[i];
         e.dp_n = ~dp[i];
         exp_q.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_an(input logic [3:0] want);
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (an_n == want) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_an: an_n stuck at %b, expected to reach %b", an_n, want);
   endtask

   task automatic next_frame();
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (frame_start) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL next_frame: frame_start=%b, expected a pulse within 60 cycles", frame_start);
   endtask

   task automatic load_value(input logic [15:0] v);
      tick();
      value_in = v;
      load     = 1'b1;
      tick();
      load     = 1'b0;
   endtask

   // Monitor: every blank->lit transition is a displayed digit and consumes one expectation.
   initial begin
      logic [3:0] prev_an;
      int         run;
      bit         track;
      int         cyc;
      int         last_fs;
      bit         fs_seen;
      exp_t       e;
      prev_an = '1;
      run     = 0;
      track   = 1'b0;
      cyc     = 0;
      last_fs = 0;
      fs_seen = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_an = '1;
            run     = 0;
            track   = 1'b0;
            fs_seen = 1'b0;
         end else begin
            if (frame_start) begin
               if (fs_seen) check("frame_period", cyc - last_fs, Frame);
               last_fs = cyc;
               fs_seen = 1'b1;
            end
            if (an_n == prev_an) begin
               run++;
            end else begin
               if (track) begin
                  if (prev_an == 4'hF) check("blank_gap", run, Blank);
                  else check("dwell", run, Dwell);
               end
               if (an_n != 4'hF && exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("digit_an_n", an_n, e.an);
                  check("digit_seg", seg, e.seg);
                  check("digit_dp_n", dp_n, e.dp_n);
               end
               track   = 1'b1;
               prev_an = an_n;
               run     = 1;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      load     = 1'b0;
      value_in = 16'h0000;
      dp_in    = 4'b0000;
      lzb_en   = 1'b0;

      // Frame 0 after reset: active = 0, no blanking.
      push_frame(S0, S0, S0, S0, 4'b0000);
      repeat (2) tick();
      @(negedge clk);
      check("reset_an_n", an_n, 4'hF);
      check("reset_seg", seg, SX);
      check("reset_dp_n", dp_n, 1'b1);
      check("reset_frame_start", frame_start, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      check("blank_after_edge1", an_n, 4'hF);
      tick();
      @(negedge clk);
      check("digit0_after_edge2", an_n, 4'b1110);

      wait_an(4'b1101);
      load_value(16'h1234);

      next_frame();                      // F1: 1234 with decimal points on digits 0 and 2
      push_frame(S1, S2, S3, S4, 4'b0101);
      tick();
      dp_in = 4'b0101;

      next_frame();                      // F2: still 1234; ABCD loaded mid-frame
      push_frame(S1, S2, S3, S4, 4'b0000);
      tick();
      dp_in = 4'b0000;
      wait_an(4'b1101);
      load_value(16'hABCD);

      next_frame();                      // F3: ABCD
      push_frame(SA, SB, SC, SD, 4'b0000);
      wait_an(4'b1101);
      load_value(16'h0050);

      next_frame();                      // F4: 0050 with leading-zero blanking, dp on blanked digit 3
      push_frame(SX, SX, S5, S0, 4'b1000);
      tick();
      lzb_en = 1'b1;
      dp_in  = 4'b1000;
      wait_an(4'b1101);
      load_value(16'h0000);

      next_frame();                      // F5: 0000 -> only digit 0 lit with a pattern
      push_frame(SX, SX, SX, S0, 4'b0000);
      tick();
      dp_in = 4'b0000;
      wait_an(4'b1101);
      load_value(16'h8888);              // pending, superseded by the boundary load below
      wait_an(4'b0111);
      repeat (3) tick();
      value_in = 16'h0F0F;
      load     = 1'b1;                   // sampled on the boundary edge
      tick();
      load     = 1'b0;

      next_frame();                      // F6: 0F0F shown in the frame that just started
      push_frame(SX, SF, S0, SF, 4'b0000);

      next_frame();                      // F7: still 0F0F (pending was dropped)
      push_frame(SX, SF, S0, SF, 4'b0000);
      wait_an(4'b1011);
      tick();
      rst_n = 1'b0;
      exp_q.delete();
      push_frame(SX, SX, SX, S0, 4'b0000);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("midshow_reset_an_n", an_n, 4'hF);
      check("midshow_reset_seg", seg, SX);
      check("midshow_reset_dp_n", dp_n, 1'b1);
      tick();
      @(negedge clk);
      check("restart_blank", an_n, 4'hF);
      tick();
      @(negedge clk);
      check("restart_digit0", an_n, 4'b1110);

      next_frame();
      repeat (3) tick();
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
